matrix_accumulator: RTL

MATRIX_ACCUMULATOR -- requirements
Module: matrix_accumulator

---
 rtl/matrix_accumulator.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/matrix_accumulator.sv
// Streaming N x N matrix builder: K unsigned terms are summed per element.
// Each sum either wraps or saturates, and the finished matrix is held for one handoff.
module matrix_accumulator #(
    parameter int ELEM_W = 6,
    parameter int N      = 2,
    parameter int K      = 2,
    parameter int SAT    = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ELEM_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N*N*ELEM_W-1:0]      out_matrix,
    output logic                       out_ovf
);

    localparam int E     = N * N;
    localparam int ACC_W = ELEM_W + $clog2(K) + 1;
    localparam int TCW   = (K > 1) ? $clog2(K) : 1;
    localparam int ECW   = (E > 1) ? $clog2(E) : 1;

    localparam logic [ACC_W-1:0] MAXV =
        {{(ACC_W-ELEM_W){1'b0}}, {ELEM_W{1'b1}}};

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [TCW-1:0]          term_cnt_q, term_cnt_d;
    logic [ECW-1:0]          elem_cnt_q, elem_cnt_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [N*N*ELEM_W-1:0]   mat_q, mat_d;
    logic                    ovf_q, ovf_d;

    logic                    xfer;
    logic                    handoff;
    logic                    last_term;
    logic                    last_elem;
    logic [ACC_W-1:0]        sum_w;
    logic                    elem_ovf;
    logic [ELEM_W-1:0]       elem_val;

    assign xfer      = in_valid && (state_q == ACCUM) && !clr;
    assign handoff   = out_ready && (state_q == HOLD) && !clr;
    assign last_term = (term_cnt_q == TCW'(K - 1));
    assign last_elem = (elem_cnt_q == ECW'(E - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clr always wins, last term enters HOLD, handoff leaves it
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ACCUM;
        end else begin
            unique case (state_q)
                ACCUM: if (xfer && last_term && last_elem) state_d = HOLD;
                HOLD:  if (out_ready) state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // Handshake outputs come straight from the state
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == HOLD);
    end

    // Element sum, overflow detect and wrap/saturate selection
    always_comb begin
        if (term_cnt_q == '0) begin
            sum_w = ACC_W'(in_data);
        end else begin
            sum_w = acc_q + ACC_W'(in_data);
        end
        elem_ovf = (sum_w > MAXV);
        if ((SAT != 0) && elem_ovf) begin
            elem_val = {ELEM_W{1'b1}};
        end else begin
            elem_val = sum_w[ELEM_W-1:0];
        end
    end

    // Datapath next state: counters, accumulator, matrix and sticky ovf
    always_comb begin
        term_cnt_d = term_cnt_q;
        elem_cnt_d = elem_cnt_q;
        acc_d      = acc_q;
        mat_d      = mat_q;
        ovf_d      = ovf_q;
        if (clr) begin
            term_cnt_d = '0;
            elem_cnt_d = '0;
            acc_d      = '0;
            ovf_d      = 1'b0;
        end else if (xfer) begin
            acc_d = sum_w;
            if (last_term) begin
                term_cnt_d = '0;
                ovf_d      = ovf_q | elem_ovf;
                for (int e = 0; e < E; e++) begin
                    if (elem_cnt_q == ECW'(e)) begin
                        mat_d[e*ELEM_W +: ELEM_W] = elem_val;
                    end
                end
                if (last_elem) begin
                    elem_cnt_d = '0;
                end else begin
                    elem_cnt_d = elem_cnt_q + ECW'(1);
                end
            end else begin
                term_cnt_d = term_cnt_q + TCW'(1);
            end
        end else if (handoff) begin
            term_cnt_d = '0;
            elem_cnt_d = '0;
            ovf_d      = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_cnt_q <= '0;
            elem_cnt_q <= '0;
            acc_q      <= '0;
            mat_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            term_cnt_q <= term_cnt_d;
            elem_cnt_q <= elem_cnt_d;
            acc_q      <= acc_d;
            mat_q      <= mat_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_matrix = mat_q;
    assign out_ovf    = ovf_q;

endmodule
